pipe_skid_stage: RTL

//  Parametrised, elastic inter-stage pipeline register for the MIPS core.
//  It generalises the fixed MEM/WB latch to any stage boundary: a configurable payload,
//  a valid/ready handshake, a 2-entry skid buffer, synchronous flush (bubble insertion),
//  $zero write squashing and a saturating back-pressure counter.
//  It sits between any two pipeline stages, e.g. MEM->WB or EX->MEM.

---
 rtl/pipe_skid_stage.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/pipe_skid_stage.sv
// Elastic inter-stage pipeline register with a 2-entry skid buffer.
//
// Sits between two pipeline stages (e.g. MEM->WB, EX->MEM). Entries move on a
// valid/ready handshake. A main register drives the outputs and a skid register
// absorbs one extra entry, so in_ready_o depends only on registered state.
//
// Ports:
//   clk_i        rising-edge clock
//   rst_i        asynchronous, active-high reset
//   flush_i      synchronous kill of all held entries (inserts a bubble)
//   in_valid_i   upstream entry present
//   in_ready_o   stage can accept an entry
//   in_wr_i      register-write enable of the entry
//   in_waddr_i   destination register
//   in_pc_i      PC of the entry
//   in_data_i    opaque payload
//   out_valid_o  entry presented downstream
//   out_ready_i  downstream accepts
//   out_wr_o     write enable (0 whenever out_valid_o=0)
//   out_waddr_o  destination register
//   out_pc_o     PC
//   out_data_o   payload
//   stall_cnt_o  saturating count of cycles with out_valid_o=1 and out_ready_i=0
module pipe_skid_stage #(
  parameter int unsigned       DATA_W      = 32,
  parameter int unsigned       PC_W        = 32,
  parameter logic [PC_W-1:0]   PC_RESET    = PC_W'(32'h0000_3000),
  parameter int unsigned       RADDR_W     = 5,
  parameter bit                ZERO_SQUASH = 1'b1,
  parameter int unsigned       STALL_W     = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               flush_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic               in_wr_i,
  input  logic [RADDR_W-1:0] in_waddr_i,
  input  logic [PC_W-1:0]    in_pc_i,
  input  logic [DATA_W-1:0]  in_data_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic               out_wr_o,
  output logic [RADDR_W-1:0] out_waddr_o,
  output logic [PC_W-1:0]    out_pc_o,
  output logic [DATA_W-1:0]  out_data_o,
  output logic [STALL_W-1:0] stall_cnt_o
);

  typedef struct packed {
    logic               wr;
    logic [RADDR_W-1:0] waddr;
    logic [PC_W-1:0]    pc;
    logic [DATA_W-1:0]  data;
  } entry_t;

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } state_e;

  localparam entry_t EmptyEntry = '{wr: 1'b0, waddr: '0, pc: PC_RESET, data: '0};

  state_e             state_q, state_d;
  entry_t             main_q, main_d;
  entry_t             skid_q, skid_d;
  logic [STALL_W-1:0] stall_q, stall_d;

  entry_t in_entry;
  logic   in_fire;
  logic   out_fire;

  // Writes to $zero are squashed at capture so neither register ever holds one.
  always_comb begin
    in_entry.waddr = in_waddr_i;
    in_entry.pc    = in_pc_i;
    in_entry.data  = in_data_i;
    in_entry.wr    = in_wr_i;
    if (ZERO_SQUASH && (in_waddr_i == '0)) begin
      in_entry.wr = 1'b0;
    end
  end

  assign in_ready_o  = (state_q != StFull);
  assign out_valid_o = (state_q != StEmpty);
  assign in_fire     = in_valid_i & in_ready_o;
  assign out_fire    = out_valid_o & out_ready_i;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush_i) begin
      state_d = StEmpty;
      main_d  = EmptyEntry;
      skid_d  = EmptyEntry;
    end else begin
      case (state_q)
        StEmpty: begin
          if (in_fire) begin
            state_d = StOne;
            main_d  = in_entry;
          end
        end
        StOne: begin
          if (in_fire && out_fire) begin
            main_d = in_entry;
          end else if (in_fire) begin
            state_d = StFull;
            skid_d  = in_entry;
          end else if (out_fire) begin
            state_d = StEmpty;
            main_d  = EmptyEntry;
          end
        end
        StFull: begin
          if (out_fire) begin
            state_d = StOne;
            main_d  = skid_q;
            skid_d  = EmptyEntry;
          end
        end
        default: begin
          state_d = StEmpty;
          main_d  = EmptyEntry;
          skid_d  = EmptyEntry;
        end
      endcase
    end
  end

  // Counter is deliberately independent of flush; only reset clears it.
  always_comb begin
    stall_d = stall_q;
    if (out_valid_o && !out_ready_i && (stall_q != {STALL_W{1'b1}})) begin
      stall_d = stall_q + STALL_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StEmpty;
      main_q  <= EmptyEntry;
      skid_q  <= EmptyEntry;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      stall_q <= stall_d;
    end
  end

  assign out_wr_o    = main_q.wr & out_valid_o;
  assign out_waddr_o = main_q.waddr;
  assign out_pc_o    = main_q.pc;
  assign out_data_o  = main_q.data;
  assign stall_cnt_o = stall_q;

endmodule
